// File: rtl/countdown_mmss.sv
// MM:SS BCD countdown timer with a per-stage borrow, a done pulse and a timed alarm.
// Every output is registered. Input priority is load > start > pause > tick.
module countdown_mmss #(
  parameter int unsigned ALARM_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_load_min,
  input  logic [7:0] i_load_sec,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_sec_bcd,
  output logic       o_sec_borrow,
  output logic       o_running,
  output logic       o_done,
  output logic       o_alarm
);

  localparam int unsigned CNT_W = $clog2(ALARM_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StAlarm} state_e;

  state_e           r_state, w_state;
  logic [7:0]       r_min, r_sec, w_min, w_sec;
  logic             r_borrow, r_done, r_running, r_alarm;
  logic             w_borrow, w_done, w_nonzero;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Saturate each digit to 9, then cap the tens digit at 5.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    logic [3:0] t;
    t = sat9(v[7:4]);
    if (t > 4'd5) t = 4'd5;
    return {t, sat9(v[3:0])};
  endfunction

  function automatic logic [7:0] dec_bcd(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_nonzero = ({r_min, r_sec} != 16'h0000);

  always_comb begin
    w_state  = r_state;
    w_min    = r_min;
    w_sec    = r_sec;
    w_borrow = 1'b0;
    w_done   = 1'b0;
    w_cnt    = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_load) begin
          w_min = clamp_bcd(i_load_min);
          w_sec = clamp_bcd(i_load_sec);
        end else if (i_start && w_nonzero) begin
          w_state = StRun;
        end
      end
      StRun: begin
        if (i_pause) begin
          w_state = StPaused;
        end else if (i_tick && w_nonzero) begin
          if (r_sec == 8'h00) begin
            w_sec    = 8'h59;
            w_min    = dec_bcd(r_min);
            w_borrow = 1'b1;
          end else begin
            w_sec = dec_bcd(r_sec);
          end
          if ({w_min, w_sec} == 16'h0000) begin
            w_done  = 1'b1;
            w_state = StAlarm;
            w_cnt   = CNT_W'(1);
          end
        end
      end
      StPaused: begin
        if (i_load) begin
          w_min = clamp_bcd(i_load_min);
          w_sec = clamp_bcd(i_load_sec);
        end else if (i_start) begin
          w_state = w_nonzero ? StRun : StIdle;
        end
      end
      StAlarm: begin
        if (i_load) begin
          w_min   = clamp_bcd(i_load_min);
          w_sec   = clamp_bcd(i_load_sec);
          w_state = StIdle;
          w_cnt   = '0;
        end else if (r_cnt >= CNT_W'(ALARM_CYCLES)) begin
          w_state = StIdle;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_borrow  <= 1'b0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_min     <= w_min;
      r_sec     <= w_sec;
      r_borrow  <= w_borrow;
      r_done    <= w_done;
      r_running <= (w_state == StRun);
      r_alarm   <= (w_state == StAlarm);
      r_cnt     <= w_cnt;
    end
  end

  assign o_min_bcd    = r_min;
  assign o_sec_bcd    = r_sec;
  assign o_sec_borrow = r_borrow;
  assign o_running    = r_running;
  assign o_done       = r_done;
  assign o_alarm      = r_alarm;

endmodule

// File: tb/tb_countdown_mmss.sv
// Scoreboard bench for countdown_mmss: directed scenarios then random stimulus,
// checked against a model that keeps the count as a plain number of seconds.
module tb_countdown_mmss;

  localparam int unsigned ALARM_CYCLES = 16;

  logic       clk = 1'b0, reset = 1'b1;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_min = 8'h00, load_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       sec_borrow, running, done, alarm;

  countdown_mmss #(.ALARM_CYCLES(ALARM_CYCLES)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_tick      (tick),
    .i_load      (load),
    .i_load_min  (load_min),
    .i_load_sec  (load_sec),
    .i_start     (start),
    .i_pause     (pause),
    .o_min_bcd   (min_bcd),
    .o_sec_bcd   (sec_bcd),
    .o_sec_borrow(sec_borrow),
    .o_running   (running),
    .o_done      (done),
    .o_alarm     (alarm)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] sc;
    logic       borrow;
    logic       run;
    logic       dn;
    logic       alm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: 0 idle, 1 run, 2 paused, 3 alarm; count kept in seconds.
  int m_state = 0;
  int m_secs  = 0;
  int m_left  = 0;

  function automatic int clamp_val(input logic [7:0] mn, input logic [7:0] sc);
    int mt, mu, st, su;
    mt = int'(mn[7:4]); mu = int'(mn[3:0]);
    st = int'(sc[7:4]); su = int'(sc[3:0]);
    if (mu > 9) mu = 9;
    if (su > 9) su = 9;
    if (mt > 5) mt = 5;
    if (st > 5) st = 5;
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic step(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                      input logic st, input logic pa, input logic tk);
    exp_t e;
    logic b, d;
    @(negedge clk);
    load = ld; load_min = lm; load_sec = ls; start = st; pause = pa; tick = tk;
    b = 1'b0; d = 1'b0;
    case (m_state)
      0: begin
        if (ld) m_secs = clamp_val(lm, ls);
        else if (st && m_secs != 0) m_state = 1;
      end
      1: begin
        if (pa) m_state = 2;
        else if (tk && m_secs > 0) begin
          if (m_secs % 60 == 0) b = 1'b1;
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            d = 1'b1;
            m_state = 3;
            m_left = ALARM_CYCLES;
          end
        end
      end
      2: begin
        if (ld) m_secs = clamp_val(lm, ls);
        else if (st) m_state = (m_secs != 0) ? 1 : 0;
      end
      default: begin
        if (ld) begin
          m_secs = clamp_val(lm, ls);
          m_state = 0;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_state = 0;
        end
      end
    endcase
    e.mn = to_bcd(m_secs / 60);
    e.sc = to_bcd(m_secs % 60);
    e.borrow = b;
    e.run = (m_state == 1);
    e.dn = d;
    e.alm = (m_state == 3);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld_val(input logic [7:0] mn, input logic [7:0] sc);
    step(1'b1, mn, sc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      if (gap) idle(1);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({min_bcd, sec_bcd, sec_borrow, running, done, alarm} != 20'h0) begin
      errors++;
      $display("FAIL %s: got min=%h sec=%h b=%b r=%b d=%b a=%b, required all zero",
               name, min_bcd, sec_bcd, sec_borrow, running, done, alarm);
    end
  endtask

  // Monitor: one registered output set per clock, compared against the queue head.
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{min_bcd, sec_bcd, sec_borrow, running, done, alarm};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got min=%h sec=%h b=%b r=%b d=%b a=%b, required min=%h sec=%h b=%b r=%b d=%b a=%b",
                   $time, g.mn, g.sc, g.borrow, g.run, g.dn, g.alm,
                   e.mn, e.sc, e.borrow, e.run, e.dn, e.alm);
        end
      end
    end
  end

  initial begin
    #95;
    check_zero("reset_hold");
    #5;
    reset = 1'b0;

    // Countdown 00:12 to zero, alarm window, back to idle.
    ld_val(8'h00, 8'h12);
    go();
    ticks(12, 1'b1);
    idle(ALARM_CYCLES + 3);

    // Borrow from minutes, twice.
    ld_val(8'h02, 8'h00);
    go();
    ticks(61, 1'b0);
    ticks(2, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Pause / resume, pause+tick in the same cycle.
    step(1'b1, 8'h00, 8'h30, 1'b0, 1'b0, 1'b0);
    go();
    ticks(3, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    ticks(5, 1'b0);
    go();
    ticks(1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Clamping, load ignored in run, load aborting alarm.
    ld_val(8'h7A, 8'h63);
    go();
    ticks(1, 1'b0);
    ld_val(8'h00, 8'h05);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    ld_val(8'h00, 8'h02);
    go();
    ticks(2, 1'b0);
    idle(3);
    ld_val(8'h00, 8'h07);
    idle(2);

    // Start at zero is ignored; load beats start.
    ld_val(8'h00, 8'h00);
    go();
    step(1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0);
    go();
    ticks(2, 1'b0);

    // Asynchronous reset mid-run, no clock edge needed.
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_zero("reset_async");
    m_state = 0; m_secs = 0; m_left = 0;
    #3;
    reset = 1'b0;
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 3),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
           8'($urandom),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 2) != 0));
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
